// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encoding and sizing helpers for the serializer
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Bit counter width; never below 1 so a 2-bit word still gets a real counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             q;
    logic             q_valid;
    logic             frame_start;
    logic             frame_done;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  q,
        input  q_valid,
        input  frame_start,
        input  frame_done
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output q,
        output q_valid,
        output frame_start,
        output frame_done
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with back-to-back word support
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    piso_serializer_if.slave   bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, sreg_shifted;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic             q_r, q_valid_r, frame_start_r, frame_done_r;
    logic             q_n, q_valid_n, frame_start_n, frame_done_n;
    logic             ready, accept, at_last;

    assign at_last      = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
    assign ready        = !reset && ((state == ST_IDLE) || at_last);
    assign accept       = bus.load_valid && ready;
    assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

    always_comb begin
        state_n   = state;
        sreg_n    = sreg;
        bit_cnt_n = bit_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n   = ST_SHIFT;
                    sreg_n    = bus.load_data;
                    bit_cnt_n = '0;
                end
            end
            ST_SHIFT: begin
                if (at_last) begin
                    bit_cnt_n = '0;
                    if (accept) begin
                        sreg_n = bus.load_data;
                    end else begin
                        state_n = ST_IDLE;
                        sreg_n  = '0;
                    end
                end else begin
                    sreg_n    = sreg_shifted;
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                sreg_n    = '0;
                bit_cnt_n = '0;
            end
        endcase

        // Outputs are decoded from next-state values so they land in flops alongside it.
        q_valid_n     = (state_n == ST_SHIFT);
        q_n           = q_valid_n && (MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0]);
        frame_start_n = q_valid_n && (bit_cnt_n == '0);
        frame_done_n  = q_valid_n && (bit_cnt_n == LAST_CNT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            sreg          <= '0;
            bit_cnt       <= '0;
            q_r           <= 1'b0;
            q_valid_r     <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
        end else begin
            state         <= state_n;
            sreg          <= sreg_n;
            bit_cnt       <= bit_cnt_n;
            q_r           <= q_n;
            q_valid_r     <= q_valid_n;
            frame_start_r <= frame_start_n;
            frame_done_r  <= frame_done_n;
        end
    end

    assign bus.load_ready  = ready;
    assign bus.q           = q_r;
    assign bus.q_valid     = q_valid_r;
    assign bus.frame_start = frame_start_r;
    assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench driving MSB-first and LSB-first serializers in lockstep
module tb_piso_serializer;

    typedef struct packed {
        logic q_m;
        logic q_l;
        logic fs;
        logic fd;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       lv    = 1'b0;
    logic [7:0] ld    = 8'h00;
    logic       accepted;
    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       sb[$];

    piso_serializer_if #(.WIDTH(8)) bus_m ();
    piso_serializer_if #(.WIDTH(8)) bus_l ();

    assign bus_m.load_valid = lv;
    assign bus_m.load_data  = ld;
    assign bus_l.load_valid = lv;
    assign bus_l.load_data  = ld;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock (clock),
        .reset (reset),
        .bus   (bus_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock (clock),
        .reset (reset),
        .bus   (bus_l)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready before the edge, predict the accept, then check the bit after it.
    task automatic tick();
        exp_t e;
        logic want_ready;
        #1;
        want_ready = !reset && (sb.size() == 0);
        check("load_ready_msb", 32'(bus_m.load_ready), 32'(want_ready));
        check("load_ready_lsb", 32'(bus_l.load_ready), 32'(want_ready));
        accepted = 1'b0;
        if (reset) begin
            sb.delete();
        end else if (lv && want_ready) begin
            for (int i = 0; i < 8; i++) begin
                e.q_m = ld[7-i];
                e.q_l = ld[i];
                e.fs  = (i == 0);
                e.fd  = (i == 7);
                sb.push_back(e);
            end
            accepted = 1'b1;
        end
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q_valid_msb", 32'(bus_m.q_valid), 32'd1);
            check("q_valid_lsb", 32'(bus_l.q_valid), 32'd1);
        end else begin
            e = '0;
            check("q_valid_msb", 32'(bus_m.q_valid), 32'd0);
            check("q_valid_lsb", 32'(bus_l.q_valid), 32'd0);
        end
        check("q_msb",           32'(bus_m.q),           32'(e.q_m));
        check("q_lsb",           32'(bus_l.q),           32'(e.q_l));
        check("frame_start_msb", 32'(bus_m.frame_start), 32'(e.fs));
        check("frame_start_lsb", 32'(bus_l.frame_start), 32'(e.fs));
        check("frame_done_msb",  32'(bus_m.frame_done),  32'(e.fd));
        check("frame_done_lsb",  32'(bus_l.frame_done),  32'(e.fd));
    endtask

    task automatic send_word(input logic [7:0] d);
        lv = 1'b1;
        ld = d;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (accepted) break;
        end
        check("accept_timeout", 32'(accepted), 32'd1);
        lv = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        tick();
    endtask

    initial begin
        // Reset held two cycles with a word offered: nothing may be accepted.
        reset = 1'b1;
        lv    = 1'b1;
        ld    = 8'hA5;
        tick();
        tick();
        lv    = 1'b0;
        reset = 1'b0;
        tick();

        // Single words from IDLE, both bit orders observed at once.
        send_word(8'hA5);
        drain();
        send_word(8'h01);
        drain();

        // Back-to-back: second word held until the frame_done cycle.
        send_word(8'hF0);
        send_word(8'h0F);
        drain();

        // Reset during bit 4 aborts the word.
        send_word(8'hFF);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        send_word(8'h81);
        drain();

        // Offered data churns mid-word; the captured word must be unaffected.
        send_word(8'h3C);
        for (int i = 0; i < 5; i++) begin
            lv = 1'b1;
            ld = 8'($urandom);
            tick();
        end
        lv = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter that produces the serial bit stream consumed by the serial shift-register chain (single-bit `d` input).
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `q`.
- `q_valid` qualifies each bit; `frame_start` and `frame_done` mark word boundaries.
- Supports back-to-back words with no idle gap.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
load_valid  input  1  `load_data` is valid this cycle.
load_ready  output  1  serializer can accept a word this cycle.
load_data  input  WIDTH  parallel word to transmit.
q  output  1  serial data bit; registered.
q_valid  output  1  `q` carries a frame bit this cycle; registered.
frame_start  output  1  high with the first bit of each word; registered.
frame_done  output  1  high with the last bit of each word; registered.

Behaviour:
- Reset (`reset`=1 at a rising edge):
  - state=IDLE, shift register=0, bit counter=0.
  - q=0, q_valid=0, frame_start=0, frame_done=0.
  - `load_ready` is forced to 0 while `reset` is high.
- Reset mid-word aborts the word with no further bits. The first cycle after reset deasserts shows IDLE outputs.
- Accept condition: load_valid && load_ready at a rising edge. `load_data` is captured only on accept. `load_valid` without ready is held off, with no side effects.
- `load_ready` is combinational from registered state: `!reset && (state==IDLE || (state==SHIFT && bit_cnt==WIDTH-1))`.
- FSM states:
  - IDLE: q=0, q_valid=0. On accept, go to SHIFT.
    - Next cycle: q = first bit, q_valid=1, frame_start=1, bit_cnt=0.
  - SHIFT: each edge advances bit_cnt by 1 and presents the next bit.
    - frame_start is 1 only when bit_cnt==0.
    - frame_done is 1 only when bit_cnt==WIDTH-1.
  - Leaving the last bit (bit_cnt==WIDTH-1):
    - With accept: stay in SHIFT, bit_cnt wraps to 0, and the new word's first bit follows immediately. frame_start and frame_done are adjacent cycles with no gap.
    - Without accept: go to IDLE; q returns to 0 and q_valid to 0.
- Latency: first bit appears 1 cycle after the accept edge. A word occupies exactly WIDTH consecutive q_valid cycles.
- Bit order:
  - MSB_FIRST=1: shift left, q = sreg[WIDTH-1].
  - MSB_FIRST=0: shift right, q = sreg[0].
  - Vacated bits fill with 0.
- bit_cnt width is $clog2(WIDTH). It never exceeds WIDTH-1.
- `load_data` changes while not accepted have no effect on the word in flight.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, SHIFT=1'b1) and a bit-counter width function (clog2).
- Single flat module; no sub-module is needed. The shift register and counter stay inline.

Test Plan:
1. Reset held 2 cycles, load_valid=1 during reset -> load_ready=0, q=0, q_valid=0; no word accepted.
2. WIDTH=8, MSB_FIRST=1, accept 8'hA5 in IDLE -> next 8 cycles q=1,0,1,0,0,1,0,1 with q_valid=1. frame_start on cycle 1, frame_done on cycle 8. Then q_valid=0 and load_ready=1.
3. MSB_FIRST=0, accept 8'hA5 -> q=1,0,1,0,0,1,0,1 (LSB first; palindrome check). Repeat with 8'h01 -> 1,0,0,0,0,0,0,0.
4. Back-to-back: accept 8'hF0, then hold load_valid with 8'h0F -> accepted on the frame_done cycle. 16 continuous q_valid cycles q=11110000 00001111, frame_start at cycles 1 and 9.
5. Reset asserted at bit 4 of 8'hFF -> next cycle q=0, q_valid=0, state IDLE. A subsequent 8'h81 is sent cleanly as 1,0,0,0,0,0,0,1.
6. load_valid=1 with load_data toggling during SHIFT (not on the last bit) -> load_ready=0 and output bits are unchanged from the captured word.
